// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
//
// Issues sequential word-aligned fetches over a req/gnt/rvalid memory interface, buffers the
// returned words with their PCs in an in-order queue, and presents the queue head to decode
// through a valid/ready handshake. A redirect restarts fetch at a new target, flushes the queue
// and drops every response that is still in flight.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   imem_req_o/addr_o      fetch request and word-aligned address
//   imem_gnt_i             request accepted this cycle
//   imem_rvalid_i/rdata_i  in-order response
//   redirect_i/pc_i        taken branch/jump and its target
//   instr_valid_o          queue head valid
//   instr_o, pc_o          queue head instruction and its PC
//   pc_plus4_o             pc_o + 4
//   instr_ready_i          decode accepts the head
module fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  input  logic                  instr_ready_i
);

  localparam int unsigned    CntW     = $clog2(DEPTH) + 1;
  localparam int unsigned    PtrW     = $clog2(DEPTH);
  localparam logic [CntW:0]  DepthLim = DEPTH[CntW:0];

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]       outst_q, outst_d;
  logic [CntW-1:0]       discard_q, discard_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];

  logic                  req;
  logic                  gnt_acc;
  logic                  push;
  logic                  pop;
  logic [CntW:0]         credit_used;
  logic [DATA_WIDTH-1:0] target_pc;

  // Outstanding requests (including ones destined to be discarded) plus buffered entries may
  // never exceed DEPTH, so every response that is kept always has a free queue slot.
  assign credit_used = {1'b0, outst_q} + {1'b0, count_q};
  // rst_ni gates the request so nothing is issued while reset is held.
  assign req         = rst_ni && !redirect_i && (credit_used < DepthLim);
  assign gnt_acc     = req && imem_gnt_i;
  assign push        = imem_rvalid_i && !redirect_i && (discard_q == '0);
  assign pop         = instr_valid_o && instr_ready_i;
  assign target_pc   = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};

  assign imem_req_o    = req;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = (count_q != '0) && !redirect_i;
  assign instr_o       = instr_mem_q[rd_ptr_q];
  assign pc_o          = pc_mem_q[rd_ptr_q];
  assign pc_plus4_o    = pc_o + DATA_WIDTH'(4);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_i) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      // Every request still in flight becomes a discard; a response arriving right now is
      // dropped directly and so is not counted.
      outst_d    = outst_q - CntW'(imem_rvalid_i);
      discard_d  = outst_q - CntW'(imem_rvalid_i);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (gnt_acc) begin
        fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
      end
      outst_d = outst_q + CntW'(gnt_acc) - CntW'(imem_rvalid_i);
      if (imem_rvalid_i && (discard_q != '0)) begin
        discard_d = discard_q - CntW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + DATA_WIDTH'(4);
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata_i;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_ready_i;

  always #5 clk = ~clk;

  fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_PC  (RESET_PC),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .instr_ready_i(instr_ready_i)
  );

  int errors = 0;
  int checks = 0;

  // Memory: granted requests waiting to respond, in order; data returned = address.
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  mreq_t mem_q[$];
  int    cyc;
  int    gnt_pct;
  int    lat_max;
  bit    mem_hold;

  // Reference model: what fetch should have in flight and buffered.
  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t        m_q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_resp_pc;
  int          m_out;
  int          m_disc;

  // Values sampled in the most recent cycle.
  logic        s_req, s_gnt, s_valid, s_rv;
  logic [31:0] s_addr, s_instr, s_pc, s_pc4;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    mem_q.delete();
    m_fetch_pc = RESET_PC;
    m_resp_pc  = RESET_PC;
    m_out      = 0;
    m_disc     = 0;
  endtask

  task automatic idle_inputs();
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit          m_req, m_valid;
    logic [31:0] tgt;
    @(negedge clk);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    instr_ready_i = rdy;
    imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    if (!mem_hold && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_q[0].addr;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hdead_beef;
    end
    #1;
    m_req   = !redir && (m_out + m_q.size() < DEPTH);
    m_valid = (m_q.size() != 0) && !redir;
    s_req = imem_req_o; s_gnt = imem_gnt_i; s_addr = imem_addr_o; s_rv = imem_rvalid_i;
    s_valid = instr_valid_o; s_instr = instr_o; s_pc = pc_o; s_pc4 = pc_plus4_o;
    check("req", 32'(s_req), 32'(m_req));
    if (m_req) check("addr", s_addr, m_fetch_pc);
    check("valid", 32'(s_valid), 32'(m_valid));
    if (m_valid) begin
      check("instr", s_instr, m_q[0].ins);
      check("pc", s_pc, m_q[0].pc);
      check("pc_plus4", s_pc4, m_q[0].pc + 32'd4);
    end
    if (s_rv) check("rvalid_has_outstanding", 32'(m_out > 0), 32'd1);
    @(posedge clk);
    cyc++;
    if (s_rv) void'(mem_q.pop_front());
    if (s_req && s_gnt) mem_q.push_back('{s_addr, cyc + $urandom_range(lat_max)});
    if (redir) begin
      tgt        = {rpc[31:2], 2'b00};
      m_out      = m_out - int'(s_rv);
      m_disc     = m_out;
      m_fetch_pc = tgt;
      m_resp_pc  = tgt;
      m_q.delete();
    end else begin
      if (m_req && s_gnt) begin
        m_out++;
        m_fetch_pc += 32'd4;
      end
      if (m_valid && rdy) void'(m_q.pop_front());
      if (s_rv) begin
        m_out--;
        if (m_disc > 0) m_disc--;
        else begin
          m_q.push_back('{m_resp_pc, imem_rdata_i});
          m_resp_pc += 32'd4;
        end
      end
    end
    check("credit", 32'(mem_q.size() + m_q.size() <= DEPTH), 32'd1);
  endtask

  logic [31:0] a_hist[6];
  logic [31:0] p_hist[6];
  logic        v_hist[6];
  int          grants, pops, hs, n;
  bit          resumed, seen;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    gnt_pct = 100; lat_max = 0; mem_hold = 1'b0; cyc = 0;
    model_reset();

    // 1: streaming with single-cycle memory.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0, 1'b1);
      a_hist[i] = s_addr; p_hist[i] = s_pc; v_hist[i] = s_valid;
    end
    check("t1_addr0", a_hist[0], 32'h0);
    check("t1_addr1", a_hist[1], 32'h4);
    check("t1_addr2", a_hist[2], 32'h8);
    check("t1_valid_c1", 32'(v_hist[1]), 32'd0);
    check("t1_valid_c2", 32'(v_hist[2]), 32'd1);
    check("t1_pc_c2", p_hist[2], 32'h0);
    check("t1_pc_c3", p_hist[3], 32'h4);
    check("t1_pc_c5", p_hist[5], 32'hC);

    // 2: decode stalled -> exactly DEPTH grants, then drain in order.
    do_reset();
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b0);
      if (s_req && s_gnt) grants++;
    end
    check("t2_grants", 32'(grants), 32'd4);
    check("t2_req_stalled", 32'(s_req), 32'd0);
    resumed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1);
      p_hist[i] = s_pc; v_hist[i] = s_valid;
      if (s_req) resumed = 1'b1;
    end
    check("t2_pop0", p_hist[0], 32'h0);
    check("t2_pop1", p_hist[1], 32'h4);
    check("t2_pop2", p_hist[2], 32'h8);
    check("t2_pop3", p_hist[3], 32'hC);
    check("t2_valid3", 32'(v_hist[3]), 32'd1);
    check("t2_resumed", 32'(resumed), 32'd1);

    // 3: redirect with 3 outstanding, target not word aligned.
    do_reset();
    mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 32'h103, 1'b0);
    check("t3_req_in_redirect", 32'(s_req), 32'd0);
    mem_hold = 1'b0;
    cycle(1'b0, '0, 1'b1);
    check("t3_addr", s_addr, 32'h100);
    check("t3_req", 32'(s_req), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, '0, 1'b0);
      if (s_valid) seen = 1'b1;
    end
    check("t3_delivered", 32'(seen), 32'd1);
    check("t3_first_pc", s_pc, 32'h100);
    check("t3_first_instr", s_instr, 32'h100);

    // 4: redirect coinciding with a response, 2 outstanding.
    do_reset();
    mem_hold = 1'b1;
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b0);
    mem_hold = 1'b0;
    cycle(1'b1, 32'h200, 1'b1);
    check("t4_rvalid_in_redirect", 32'(s_rv), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, '0, 1'b0);
      if (s_valid) seen = 1'b1;
    end
    check("t4_delivered", 32'(seen), 32'd1);
    check("t4_first_pc", s_pc, 32'h200);

    // 5: random stalls, latencies and occasional redirects.
    do_reset();
    gnt_pct = 45; lat_max = 5;
    hs = 0; n = 0;
    while (hs < 1000 && n < 30000) begin
      automatic bit redir = ($urandom_range(99) < 2);
      automatic bit rdy   = ($urandom_range(99) < 70);
      cycle(redir, $urandom, rdy);
      if (s_valid && rdy) begin
        hs++;
        check("t5_instr_eq_pc", s_instr, s_pc);
      end
      n++;
    end
    check("t5_handshakes", 32'(hs >= 1000), 32'd1);

    // 6: reset mid-stream with 3 entries buffered.
    do_reset();
    gnt_pct = 100; lat_max = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, '0, 1'b0);
      if (m_q.size() == 3) seen = 1'b1;
    end
    check("t6_three_buffered", 32'(seen), 32'd1);
    #2;
    check("t6_valid_before", 32'(instr_valid_o), 32'd1);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("t6_req_in_reset", 32'(imem_req_o), 32'd0);
    check("t6_valid_in_reset", 32'(instr_valid_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    cycle(1'b0, '0, 1'b1);
    check("t6_first_addr", s_addr, RESET_PC);
    check("t6_first_req", 32'(s_req), 32'd1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
